// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
//   Execute-stage ALU: decodes ALUOp/Funct into a 4-bit operation code and
//   produces a registered result. Single-cycle ops complete one cycle after
//   accept; the optional unsigned mul/mulhu/divu/remu ops iterate one bit per
//   cycle behind an in_valid/in_ready handshake so the hazard unit can stall EX.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   in_valid/in_ready operand handshake; in_ready is high only in IDLE
//   flush             kills an in-flight op and blocks an accept this cycle
//   ALUOp, Funct      op class and {funct7[5], funct3}
//   a, b              WIDTH-bit operands
//   out_valid         one-cycle pulse qualifying result/Operation/zero
//   result, Operation registered result and decoded op code
//   zero              result == 0, qualified by out_valid
// -----------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int WIDTH     = 64,
    parameter int MULDIV_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    input  logic [1:0]       ALUOp,
    input  logic [3:0]       Funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       Operation,
    output logic             zero
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_SRL   = 4'b0100;
    localparam logic [3:0] OP_SRA   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b1000;
    localparam logic [3:0] OP_MUL   = 4'b1001;
    localparam logic [3:0] OP_MULHU = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
    localparam logic [3:0] OP_REMU  = 4'b1100;
    localparam logic [3:0] OP_SLL   = 4'b1111;

    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

    function automatic logic [3:0] decode_op(input logic [1:0] alu_op, input logic [3:0] funct);
        logic [3:0] op;
        op = OP_ADD;
        case (alu_op)
            2'b00: op = (funct == 4'b0001) ? OP_SLL : OP_ADD;
            2'b01: op = OP_SUB;
            2'b10: begin
                case (funct)
                    4'b0000: op = OP_ADD;
                    4'b1000: op = OP_SUB;
                    4'b0111: op = OP_AND;
                    4'b0110: op = OP_OR;
                    4'b0100: op = OP_XOR;
                    4'b0001: op = OP_SLL;
                    4'b0101: op = OP_SRL;
                    4'b1101: op = OP_SRA;
                    4'b0010: op = OP_SLT;
                    4'b0011: op = OP_SLTU;
                    default: op = OP_ADD;
                endcase
            end
            default: begin
                // Without the mul/div path this class degrades to a plain add.
                if (MULDIV_EN != 0) begin
                    case (funct[2:0])
                        3'b011:  op = OP_MULHU;
                        3'b101:  op = OP_DIVU;
                        3'b111:  op = OP_REMU;
                        default: op = OP_MUL;
                    endcase
                end
            end
        endcase
        return op;
    endfunction

    function automatic logic [WIDTH-1:0] alu_compute(input logic [3:0] op,
                                                     input logic [WIDTH-1:0] x,
                                                     input logic [WIDTH-1:0] y);
        logic signed [WIDTH-1:0] xs;
        logic signed [WIDTH-1:0] ys;
        logic [SHW-1:0]          sh;
        logic [WIDTH-1:0]        r;
        xs = x;
        ys = y;
        sh = y[SHW-1:0];
        case (op)
            OP_SUB:  r = x - y;
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_XOR:  r = x ^ y;
            OP_SLL:  r = x << sh;
            OP_SRL:  r = x >> sh;
            OP_SRA:  r = xs >>> sh;
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, (xs < ys)};
            OP_SLTU: r = {{(WIDTH-1){1'b0}}, (x < y)};
            default: r = x + y;
        endcase
        return r;
    endfunction

    state_t               state_q, state_d;
    logic [SHW-1:0]       cnt_q, cnt_d;
    logic [3:0]           pend_op_q, pend_op_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [3:0]           operation_q, operation_d;
    logic                 zero_q, zero_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;     // {hi, lo}: product, or {remainder, quotient}
    logic [WIDTH-1:0]     opnd_q, opnd_d;   // multiplicand or divisor

    logic                 accept;
    logic                 last_iter;
    logic [3:0]           dec_op;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_cand;
    logic [WIDTH:0]       div_trial;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   fin_full;
    logic [WIDTH-1:0]     fin_res;

    assign in_ready  = (state_q == IDLE);
    assign accept    = in_valid & in_ready & ~flush;
    assign dec_op    = decode_op(ALUOp, Funct);
    assign last_iter = (cnt_q == SHW'(WIDTH - 1));

    // Shift-add step: add multiplicand into the high half when the current
    // multiplier bit (acc LSB) is set, then shift the whole accumulator right.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring step: shift the next dividend bit into the remainder and keep
    // the difference only if it did not borrow. A zero divisor never borrows,
    // which yields an all-ones quotient and a remainder equal to the dividend.
    assign div_cand  = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_trial = div_cand - {1'b0, opnd_q};
    assign div_next  = div_trial[WIDTH] ? {div_cand[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    assign fin_full = (state_q == MUL) ? mul_next : div_next;
    assign fin_res  = (pend_op_q == OP_MUL || pend_op_q == OP_DIVU) ? fin_full[WIDTH-1:0]
                                                                    : fin_full[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_op_d   = pend_op_q;
        out_valid_d = 1'b0;
        result_d    = result_q;
        operation_d = operation_q;
        zero_d      = zero_q;
        acc_d       = acc_q;
        opnd_d      = opnd_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (dec_op == OP_MUL || dec_op == OP_MULHU ||
                        dec_op == OP_DIVU || dec_op == OP_REMU) begin
                        state_d   = (dec_op == OP_MUL || dec_op == OP_MULHU) ? MUL : DIV;
                        cnt_d     = '0;
                        pend_op_d = dec_op;
                        acc_d     = {{WIDTH{1'b0}}, a};
                        opnd_d    = b;
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = alu_compute(dec_op, a, b);
                        operation_d = dec_op;
                        zero_d      = (result_d == '0);
                    end
                end
            end
            MUL, DIV: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = fin_full;
                    cnt_d = cnt_q + SHW'(1);
                    if (last_iter) begin
                        state_d     = DONE;
                        result_d    = fin_res;
                        operation_d = pend_op_q;
                        zero_d      = (fin_res == '0);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pend_op_q   <= OP_ADD;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            operation_q <= OP_ADD;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_op_q   <= pend_op_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            operation_q <= operation_d;
            zero_q      <= zero_d;
        end
    end

    // Iteration datapath carries no reset; it is reloaded on every accept.
    always_ff @(posedge clk) begin
        acc_q  <= acc_d;
        opnd_q <= opnd_d;
    end

    // Iterative results are presented during DONE; a flush there withdraws them.
    assign out_valid = out_valid_q | ((state_q == DONE) & ~flush);
    assign result    = result_q;
    assign Operation = operation_q;
    assign zero      = out_valid & zero_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;
    localparam int W = 64;
    localparam logic [W-1:0] ONES = {W{1'b1}};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, in_valid, flush;
    logic [1:0]   ALUOp;
    logic [3:0]   Funct;
    logic [W-1:0] a, b;
    logic         in_ready, out_valid, zero;
    logic [W-1:0] result;
    logic [3:0]   Operation;
    logic         n_in_ready, n_out_valid, n_zero;
    logic [W-1:0] n_result;
    logic [3:0]   n_Operation;

    int n_checks = 0;
    int n_fail   = 0;

    alu_exec_unit #(.WIDTH(W), .MULDIV_EN(1)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .ALUOp(ALUOp), .Funct(Funct), .a(a), .b(b),
        .out_valid(out_valid), .result(result), .Operation(Operation), .zero(zero)
    );

    alu_exec_unit #(.WIDTH(W), .MULDIV_EN(0)) u_nomd (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(n_in_ready),
        .flush(flush), .ALUOp(ALUOp), .Funct(Funct), .a(a), .b(b),
        .out_valid(n_out_valid), .result(n_result), .Operation(n_Operation), .zero(n_zero)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one op, wait (bounded) for out_valid, then step one more cycle
    // to confirm the pulse ended and the unit is ready again.
    task automatic run_op(input logic [1:0] op_c, input logic [3:0] fn,
                          input logic [W-1:0] x, input logic [W-1:0] y,
                          output logic [W-1:0] r, output logic [3:0] o, output logic z,
                          output int lat, output int rdy_low);
        ALUOp = op_c; Funct = fn; a = x; b = y; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        lat = 1;
        rdy_low = 0;
        while (!out_valid && lat < 200) begin
            if (!in_ready) rdy_low++;
            tick;
            lat++;
        end
        if (!in_ready) rdy_low++;
        r = result; o = Operation; z = zero;
        tick;
        chk("ov_pulse", {63'd0, out_valid}, 64'd0);
        chk("rdy_after", {63'd0, in_ready}, 64'd1);
    endtask

    function automatic logic [3:0] exp_op(input logic [1:0] op_c, input logic [3:0] fn);
        case (op_c)
            2'd0: return (fn == 4'b0001) ? 4'b1111 : 4'b0010;
            2'd1: return 4'b0110;
            2'd2: begin
                case (fn)
                    4'b0000: return 4'b0010;
                    4'b1000: return 4'b0110;
                    4'b0111: return 4'b0000;
                    4'b0110: return 4'b0001;
                    4'b0100: return 4'b0011;
                    4'b0001: return 4'b1111;
                    4'b0101: return 4'b0100;
                    4'b1101: return 4'b0101;
                    4'b0010: return 4'b0111;
                    4'b0011: return 4'b1000;
                    default: return 4'b0010;
                endcase
            end
            default: begin
                case (fn[2:0])
                    3'b011:  return 4'b1010;
                    3'b101:  return 4'b1011;
                    3'b111:  return 4'b1100;
                    default: return 4'b1001;
                endcase
            end
        endcase
    endfunction

    // Hand-computed results for a = 0x0F, b = 3.
    function automatic logic [W-1:0] exp_res_f3(input logic [3:0] op);
        case (op)
            4'b0010: return 64'h12;
            4'b0110: return 64'h0C;
            4'b0000: return 64'h03;
            4'b0001: return 64'h0F;
            4'b0011: return 64'h0C;
            4'b1111: return 64'h78;
            4'b0100: return 64'h01;
            4'b0101: return 64'h01;
            4'b1001: return 64'h2D;
            4'b1011: return 64'h05;
            default: return 64'h00;
        endcase
    endfunction

    initial begin
        logic [W-1:0] r;
        logic [3:0]   o;
        logic         z;
        int           lat, rl, cnt;
        logic [3:0]   eo;

        reset = 1'b1; in_valid = 1'b0; flush = 1'b0;
        ALUOp = 2'd0; Funct = 4'd0; a = '0; b = '0;
        repeat (3) tick;
        reset = 1'b0;
        tick;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_operation", {60'd0, Operation}, 64'd2);
        chk("rst_zero", {63'd0, zero}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Decode sweep over every ALUOp/Funct pair
        for (int oc = 0; oc < 4; oc++) begin
            for (int f = 0; f < 16; f++) begin
                run_op(2'(oc), 4'(f), 64'h0F, 64'h3, r, o, z, lat, rl);
                eo = exp_op(2'(oc), 4'(f));
                chk("sweep_op", {60'd0, o}, {60'd0, eo});
                chk("sweep_res", r, exp_res_f3(eo));
                chk("sweep_lat", 64'(lat), (oc == 3) ? 64'd65 : 64'd1);
            end
        end

        // Back-to-back single-cycle ops
        ALUOp = 2'd0; Funct = 4'd0; a = 64'd1; b = 64'd2; in_valid = 1'b1;
        tick;
        chk("b2b_res0", result, 64'd3);
        a = 64'd5; b = 64'd6;
        tick;
        chk("b2b_ov1", {63'd0, out_valid}, 64'd1);
        chk("b2b_res1", result, 64'd11);
        in_valid = 1'b0;
        tick;

        // Arithmetic corners
        run_op(2'b01, 4'b0000, 64'd0, 64'd1, r, o, z, lat, rl);
        chk("sub_wrap", r, ONES);
        chk("sub_wrap_zero", {63'd0, z}, 64'd0);
        run_op(2'b10, 4'b1101, 64'h8000_0000_0000_0000, 64'd63, r, o, z, lat, rl);
        chk("sra63", r, ONES);
        run_op(2'b10, 4'b0010, ONES, 64'd1, r, o, z, lat, rl);
        chk("slt_neg", r, 64'd1);
        run_op(2'b10, 4'b0011, ONES, 64'd1, r, o, z, lat, rl);
        chk("sltu_neg", r, 64'd0);
        run_op(2'b01, 4'b0111, 64'h55, 64'h55, r, o, z, lat, rl);
        chk("beq_zero", {63'd0, z}, 64'd1);
        chk("beq_res", r, 64'd0);

        // Multiply
        run_op(2'b11, 4'b0000, ONES, 64'd2, r, o, z, lat, rl);
        chk("mul_res", r, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("mul_lat", 64'(lat), 64'd65);
        chk("mul_rdy_low", 64'(rl), 64'd65);
        chk("mul_op", {60'd0, o}, 64'h9);
        run_op(2'b11, 4'b0011, ONES, 64'd2, r, o, z, lat, rl);
        chk("mulhu_res", r, 64'd1);

        // Divide
        run_op(2'b11, 4'b0101, 64'd100, 64'd7, r, o, z, lat, rl);
        chk("divu_res", r, 64'd14);
        chk("divu_lat", 64'(lat), 64'd65);
        run_op(2'b11, 4'b0111, 64'd100, 64'd7, r, o, z, lat, rl);
        chk("remu_res", r, 64'd2);
        run_op(2'b11, 4'b0101, 64'h1234, 64'd0, r, o, z, lat, rl);
        chk("divu_by0", r, ONES);
        run_op(2'b11, 4'b0111, 64'd5, 64'd0, r, o, z, lat, rl);
        chk("remu_by0", r, 64'd5);

        // Flush at iteration 10 of a divu
        ALUOp = 2'b11; Funct = 4'b0101; a = 64'd100; b = 64'd7; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (10) tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        chk("flush_ov", {63'd0, out_valid}, 64'd0);
        chk("flush_rdy", {63'd0, in_ready}, 64'd1);
        run_op(2'b10, 4'b0000, 64'd1, 64'd1, r, o, z, lat, rl);
        chk("post_flush_add", r, 64'd2);
        chk("post_flush_lat", 64'(lat), 64'd1);
        cnt = 0;
        for (int i = 0; i < 70; i++) begin
            if (out_valid) cnt++;
            tick;
        end
        chk("flush_no_late_ov", 64'(cnt), 64'd0);

        // Flush with in_valid in IDLE accepts nothing
        ALUOp = 2'b00; Funct = 4'd0; a = 64'd9; b = 64'd9; in_valid = 1'b1; flush = 1'b1;
        tick;
        in_valid = 1'b0; flush = 1'b0;
        chk("idle_flush_ov", {63'd0, out_valid}, 64'd0);
        chk("idle_flush_res", result, 64'd2);

        // Reset at iteration 30 of a mul
        ALUOp = 2'b11; Funct = 4'b0000; a = ONES; b = 64'd2; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (30) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("midrst_ov", {63'd0, out_valid}, 64'd0);
        chk("midrst_res", result, 64'd0);
        chk("midrst_op", {60'd0, Operation}, 64'd2);
        chk("midrst_rdy", {63'd0, in_ready}, 64'd1);
        cnt = 0;
        for (int i = 0; i < 70; i++) begin
            if (out_valid) cnt++;
            tick;
        end
        chk("midrst_no_ov", 64'(cnt), 64'd0);

        // MULDIV_EN=0: ALUOp 11 is a single-cycle add
        chk("nomd_rdy", {63'd0, n_in_ready}, 64'd1);
        ALUOp = 2'b11; Funct = 4'b0000; a = 64'd3; b = 64'd4; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        chk("nomd_ov", {63'd0, n_out_valid}, 64'd1);
        chk("nomd_res", n_result, 64'd7);
        chk("nomd_op", {60'd0, n_Operation}, 64'd2);
        chk("nomd_zero", {63'd0, n_zero}, 64'd0);
        chk("md_busy", {63'd0, in_ready}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
